// File: rtl/seq_1010_pkg.sv
// Shared definitions for the 1010 frame transmitter and detector.
// SEQ_1010_TX_PARITY_EN adds the PAR state to the encoding.
package seq_1010_pkg;

    localparam logic [3:0] PREAMBLE = 4'b1010;
    localparam int PRE_LEN = 4;

`ifdef SEQ_1010_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAR,
        GAP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        GAP
    } state_t;
`endif

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_bit_timer.sv
// Bit-period divider: bit_tick marks the last cycle of each bit.
module seq_bit_timer #(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_tick
);

    localparam int W = $clog2(BIT_DIV + 1);
    localparam logic [W-1:0] LAST = W'(BIT_DIV - 1);

    logic [W-1:0] cnt;

    assign bit_tick = run && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_1010_tx.sv
// Serial frame transmitter: preamble 1010, data MSB-first, low gap.
// Define SEQ_1010_TX_PARITY_EN to append an even-parity bit.
module seq_1010_tx
    import seq_1010_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BIT_DIV  = 1,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_out,
    output logic              tx_active,
    output logic              done
);

    localparam int BMAX = max3(PRE_LEN, DATA_W, GAP_BITS);
    localparam int CW = $clog2(BMAX + 1);
    localparam int SW = PRE_LEN + DATA_W;
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_BITS - 1);

    state_t          state, state_n;
    logic [CW-1:0]   bit_cnt, bit_cnt_n;
    logic [SW-1:0]   shreg, shreg_n;
    logic            tx_n;
    logic            done_n;
    logic            bit_tick;
`ifdef SEQ_1010_TX_PARITY_EN
    logic            par, par_n;
`endif

    assign tx_active = (state != IDLE);
    assign in_ready  = (state == IDLE);

    seq_bit_timer #(
        .BIT_DIV(BIT_DIV)
    ) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .run(tx_active),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            tx_out  <= 1'b0;
            done    <= 1'b0;
`ifdef SEQ_1010_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            tx_out  <= tx_n;
            done    <= done_n;
`ifdef SEQ_1010_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    // Preamble and payload share one shift register; the first
    // preamble bit goes straight to tx_out at the handshake edge.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        tx_n      = tx_out;
        done_n    = 1'b0;
`ifdef SEQ_1010_TX_PARITY_EN
        par_n     = par;
`endif
        unique case (state)
            IDLE: begin
                tx_n = 1'b0;
                if (in_valid) begin
                    state_n   = PRE;
                    bit_cnt_n = '0;
                    shreg_n   = {PREAMBLE[PRE_LEN-2:0], in_data, 1'b0};
                    tx_n      = PREAMBLE[PRE_LEN-1];
`ifdef SEQ_1010_TX_PARITY_EN
                    par_n     = ^in_data;
`endif
                end
            end
            PRE: begin
                if (bit_tick) begin
                    tx_n    = shreg[SW-1];
                    shreg_n = shreg << 1;
                    if (bit_cnt == PRE_LAST) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_n = '0;
`ifdef SEQ_1010_TX_PARITY_EN
                        state_n   = PAR;
                        tx_n      = par;
`else
                        state_n   = GAP;
                        tx_n      = 1'b0;
`endif
                    end else begin
                        tx_n      = shreg[SW-1];
                        shreg_n   = shreg << 1;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef SEQ_1010_TX_PARITY_EN
            PAR: begin
                if (bit_tick) begin
                    state_n   = GAP;
                    bit_cnt_n = '0;
                    tx_n      = 1'b0;
                end
            end
`endif
            GAP: begin
                tx_n = 1'b0;
                if (bit_tick) begin
                    if (bit_cnt == GAP_LAST) begin
                        state_n   = IDLE;
                        bit_cnt_n = '0;
                        done_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_1010_tx.sv
// Scoreboard bench for seq_1010_tx at BIT_DIV=1 and BIT_DIV=3.
// Honours SEQ_1010_TX_PARITY_EN when building expected frames.
module tb_seq_1010_tx;

`ifdef SEQ_1010_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int FLEN = 4 + 8 + PAR_EN + 2;

    typedef struct packed {
        logic tx;
        logic act;
        logic dn;
        logic rdy;
    } exp_t;

    localparam exp_t IDLE_E = '{tx: 1'b0, act: 1'b0, dn: 1'b0, rdy: 1'b1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       v1 = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic       r1, tx1, a1, dn1;
    logic       v3 = 1'b0;
    logic [7:0] d3 = 8'h00;
    logic       r3, tx3, a3, dn3;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_1010_tx #(.DATA_W(8), .BIT_DIV(1), .GAP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1),
        .in_ready(r1), .tx_out(tx1), .tx_active(a1), .done(dn1)
    );

    seq_1010_tx #(.DATA_W(8), .BIT_DIV(3), .GAP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3),
        .in_ready(r3), .tx_out(tx3), .tx_active(a3), .done(dn3)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic fbit(input logic [7:0] d, input int i);
        logic [3:0] pre;
        pre = 4'b1010;
        if (i < 4) return pre[3-i];
        if (i < 12) return d[11-i];
        if (PAR_EN == 1 && i == 12) return ^d;
        return 1'b0;
    endfunction

    // Model: sample at negedge, pop the expected cycle, and queue a
    // whole frame when a handshake will happen on the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            q3.delete();
        end
        e1 = (q1.size() > 0) ? q1.pop_front() : IDLE_E;
        e3 = (q3.size() > 0) ? q3.pop_front() : IDLE_E;
        chk("d1_tx", tx1, e1.tx);
        chk("d1_active", a1, e1.act);
        chk("d1_done", dn1, e1.dn);
        chk("d1_ready", r1, e1.rdy);
        chk("d3_tx", tx3, e3.tx);
        chk("d3_active", a3, e3.act);
        chk("d3_done", dn3, e3.dn);
        chk("d3_ready", r3, e3.rdy);
        if (rst_n && v1 && e1.rdy) begin
            for (int i = 0; i < FLEN; i++)
                q1.push_back('{tx: fbit(d1, i), act: 1'b1, dn: 1'b0, rdy: 1'b0});
            q1.push_back('{tx: 1'b0, act: 1'b0, dn: 1'b1, rdy: 1'b1});
        end
        if (rst_n && v3 && e3.rdy) begin
            for (int i = 0; i < FLEN; i++)
                repeat (3)
                    q3.push_back('{tx: fbit(d3, i), act: 1'b1, dn: 1'b0, rdy: 1'b0});
            q3.push_back('{tx: 1'b0, act: 1'b0, dn: 1'b1, rdy: 1'b1});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx", tx1, 1'b0);
        chk("rst_ready", r1, 1'b1);
        chk("rst_active", a1, 1'b0);
        chk("rst_done", dn1, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(50);

        // single frame 0xA5, BIT_DIV=1
        v1 = 1'b1;
        d1 = 8'hA5;
        tick(1);
        v1 = 1'b0;
        d1 = 8'h00;
        tick(20);

        // single frame 0xA5, BIT_DIV=3
        v3 = 1'b1;
        d3 = 8'hA5;
        tick(1);
        v3 = 1'b0;
        d3 = 8'h5A;
        tick(50);

        // back-to-back with data changing during frame 1
        v1 = 1'b1;
        d1 = 8'hFF;
        tick(1);
        tick(8);
        d1 = 8'h3C;
        tick(2);
        d1 = 8'h00;
        tick(5);
        v1 = 1'b0;
        d1 = 8'hC3;
        tick(20);

        // asynchronous reset mid-frame
        v1 = 1'b1;
        d1 = 8'h5A;
        tick(1);
        v1 = 1'b0;
        tick(5);
        chk("pre_rst_tx", tx1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_tx", tx1, 1'b0);
        chk("arst_ready", r1, 1'b1);
        chk("arst_active", a1, 1'b0);
        chk("arst_done", dn1, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(3);

        // frame after reset, then parity corner 0x01
        v1 = 1'b1;
        d1 = 8'hC3;
        tick(1);
        v1 = 1'b0;
        tick(20);
        v1 = 1'b1;
        d1 = 8'h01;
        v3 = 1'b1;
        d3 = 8'h01;
        tick(1);
        v1 = 1'b0;
        v3 = 1'b0;
        tick(50);

        chk("q1_drained", q1.size() == 0, 1'b1);
        chk("q3_drained", q3.size() == 0, 1'b1);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
